wishbone_timer_slave: RTL and testbench



---
 rtl/wishbone_timer_slave_pkg.sv | 22 ++
 rtl/wishbone_timer_slave_prescaler.sv | 28 ++
 rtl/wishbone_timer_slave.sv | 128 ++++++++++++
 tb/tb_wishbone_timer_slave.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_timer_slave_pkg.sv
// Shared register map and bit positions for the Wishbone timer slave.
package wishbone_timer_slave_pkg;

  localparam int unsigned TMR_CTRL   = 0;
  localparam int unsigned TMR_PRESC  = 1;
  localparam int unsigned TMR_RELOAD = 2;
  localparam int unsigned TMR_COUNT  = 3;
  localparam int unsigned TMR_STATUS = 4;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_AUTO = 1;
  localparam int unsigned CTRL_IE   = 2;

  localparam int unsigned STATUS_FLAG = 0;

  localparam int unsigned CTRL_W = 3;

  function automatic logic [7:0] ctrl_byte(input logic [CTRL_W-1:0] ctrl);
    return {{(8 - CTRL_W){1'b0}}, ctrl};
  endfunction

endpackage

// File: rtl/wishbone_timer_slave_prescaler.sv
// Free-running prescaler: emits a one-cycle tick every (limit+1) enabled cycles.
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       restart,
  input  logic [7:0] limit,
  output logic       tick
);

  logic [7:0] pcnt;
  logic       at_limit;

  assign at_limit = (pcnt == limit);
  // A restart on a terminal cycle swallows that tick.
  assign tick     = enable & ~restart & at_limit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (!enable || restart || at_limit) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 8'd1;
    end
  end

endmodule

// File: rtl/wishbone_timer_slave.sv
// Wishbone slave with an 8-bit down-counting timer, prescaler and maskable interrupt.
module wishbone_timer_slave
  import wishbone_timer_slave_pkg::*;
#(
  parameter int unsigned ADDR_W         = 3,
  parameter logic [7:0]  RESET_PRESCALE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] dir_i,
  input  logic              we_i,
  input  logic              stb_i,
  input  logic              cyc_i,
  input  logic [7:0]        dat_i,
  output logic [7:0]        dat_o,
  output logic              ack_o,
  output logic              irq_o
);

  logic              req;
  logic              wr;
  logic              ctrl_wr;
  logic              presc_wr;
  logic              reload_wr;
  logic              status_wr;
  logic              tick;
  logic              expire;
  logic [CTRL_W-1:0] ctrl;
  logic [7:0]        presc;
  logic [7:0]        reload;
  logic [7:0]        count;
  logic              flag;
  logic [7:0]        rd_data;

  assign req    = stb_i & cyc_i & ~ack_o;
  assign wr     = req & we_i;
  assign expire = tick & (count == '0);
  assign irq_o  = flag & ctrl[CTRL_IE];

  always_comb begin
    ctrl_wr   = 1'b0;
    presc_wr  = 1'b0;
    reload_wr = 1'b0;
    status_wr = 1'b0;
    rd_data   = '0;
    case (32'(dir_i))
      TMR_CTRL: begin
        ctrl_wr = wr;
        rd_data = ctrl_byte(ctrl);
      end
      TMR_PRESC: begin
        presc_wr = wr;
        rd_data  = presc;
      end
      TMR_RELOAD: begin
        reload_wr = wr;
        rd_data   = reload;
      end
      TMR_COUNT: begin
        rd_data = count;
      end
      TMR_STATUS: begin
        status_wr             = wr;
        rd_data[STATUS_FLAG]  = flag;
      end
      default: ;
    endcase
  end

  timer_prescaler u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .enable  (ctrl[CTRL_EN]),
    .restart (reload_wr),
    .limit   (presc),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= req;
      if (req) begin
        dat_o <= rd_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl   <= '0;
      presc  <= RESET_PRESCALE;
      reload <= '0;
      count  <= '0;
      flag   <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl <= dat_i[CTRL_W-1:0];
      end
      if (presc_wr) begin
        presc <= dat_i;
      end
      // tick is already suppressed by a RELOAD write, so the write owns COUNT.
      if (reload_wr) begin
        reload <= dat_i;
        count  <= dat_i;
      end else if (tick) begin
        if (count != '0) begin
          count <= count - 8'd1;
        end else if (ctrl[CTRL_AUTO]) begin
          count <= reload;
        end
      end
      // One-shot expiry overrides a concurrent CTRL write to EN.
      if (expire && !ctrl[CTRL_AUTO]) begin
        ctrl[CTRL_EN] <= 1'b0;
      end
      if (expire) begin
        flag <= 1'b1;
      end else if (status_wr && dat_i[STATUS_FLAG]) begin
        flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wishbone_timer_slave.sv
// Randomized and directed bench for wishbone_timer_slave against a cycle reference model.
module tb_wishbone_timer_slave;

  localparam logic [7:0] RST_PS = 8'h3C;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dir = '0;
  logic       we  = 1'b0;
  logic       stb = 1'b0;
  logic       cyc = 1'b0;
  logic [7:0] dat = '0;
  logic [7:0] dat_o;
  logic       ack_o;
  logic       irq_o;

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;
  int last_commit = 0;
  logic chk_on = 1'b0;

  // reference model state
  logic       m_en, m_auto, m_ie, m_flag, m_ack;
  logic [7:0] m_presc, m_reload, m_count, m_dat;
  int         m_age;

  wishbone_timer_slave #(
    .ADDR_W         (3),
    .RESET_PRESCALE (RST_PS)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .dir_i (dir),
    .we_i  (we),
    .stb_i (stb),
    .cyc_i (cyc),
    .dat_i (dat),
    .dat_o (dat_o),
    .ack_o (ack_o),
    .irq_o (irq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  // Timer behaviour: tick when (enabled cycles since start) mod (PRESCALE+1) hits PRESCALE.
  always @(posedge clk or posedge rst) begin : ref_model
    logic       req, wr, rl_wr, tick;
    logic [7:0] rd, c, ps, rl;
    logic       e, a, ie, f;
    if (rst) begin
      m_en <= 1'b0; m_auto <= 1'b0; m_ie <= 1'b0; m_flag <= 1'b0;
      m_presc <= RST_PS; m_reload <= '0; m_count <= '0;
      m_age <= 0; m_ack <= 1'b0; m_dat <= '0;
    end else begin
      req   = stb && cyc && !m_ack;
      wr    = req && we;
      rl_wr = wr && (dir == 3'd2);
      tick  = m_en && !rl_wr && ((m_age % (int'(m_presc) + 1)) == int'(m_presc));
      case (dir)
        3'd0:    rd = {5'd0, m_ie, m_auto, m_en};
        3'd1:    rd = m_presc;
        3'd2:    rd = m_reload;
        3'd3:    rd = m_count;
        3'd4:    rd = {7'd0, m_flag};
        default: rd = 8'd0;
      endcase
      e = m_en; a = m_auto; ie = m_ie; f = m_flag;
      c = m_count; ps = m_presc; rl = m_reload;
      if (wr) begin
        case (dir)
          3'd0: begin e = dat[0]; a = dat[1]; ie = dat[2]; end
          3'd1: ps = dat;
          3'd2: begin rl = dat; c = dat; end
          3'd4: if (dat[0]) f = 1'b0;
          default: ;
        endcase
      end
      if (tick) begin
        if (m_count != 8'd0) c = m_count - 8'd1;
        else begin
          f = 1'b1;
          if (m_auto) c = m_reload;
          else e = 1'b0;
        end
      end
      m_age    <= (!m_en || rl_wr) ? 0 : m_age + 1;
      m_en     <= e; m_auto <= a; m_ie <= ie; m_flag <= f;
      m_count  <= c; m_presc <= ps; m_reload <= rl;
      m_ack    <= req;
      if (req) m_dat <= rd;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("ack", ack_o, m_ack);
      check("irq", irq_o, m_flag & m_ie);
      check("dat", dat_o, m_dat);
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    dir = a; dat = d; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    @(posedge clk);
    #1 last_commit = cyc_n;
    check("wr_ack", ack_o, 1);
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk);
    #1 check("wr_ack_end", ack_o, 0);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    dir = a; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    @(posedge clk);
    #1 check("rd_ack", ack_o, 1);
    d = dat_o;
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0;
    @(posedge clk);
    #1 check("rd_ack_end", ack_o, 0);
  endtask

  task automatic read_expect(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_irq(output int at);
    at = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (irq_o === 1'b1) begin
        at = cyc_n;
        return;
      end
    end
    check("irq_timeout", 0, 1);
  endtask

  task automatic read_all_reset(input string tag);
    for (int i = 0; i < 8; i++) begin
      read_expect(tag, 3'(i), (i == 1) ? RST_PS : 8'h00);
    end
  endtask

  initial begin
    int n1, n2;
    logic [7:0] d;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    check("rst_ack", ack_o, 0);
    check("rst_irq", irq_o, 0);
    read_all_reset("rst_read");

    // one-shot: expiry 12 cycles after CTRL commit
    bus_write(3'd1, 8'h02);
    bus_write(3'd2, 8'h03);
    bus_write(3'd0, 8'h05);
    n1 = last_commit;
    wait_irq(n2);
    check("oneshot_lat", n2 - n1, 12);
    read_expect("oneshot_ctrl", 3'd0, 8'h04);
    read_expect("oneshot_count", 3'd3, 8'h00);
    read_expect("oneshot_flag", 3'd4, 8'h01);
    bus_write(3'd4, 8'h01);
    repeat (50) @(negedge clk);
    read_expect("oneshot_quiet", 3'd4, 8'h00);
    check("oneshot_irq_low", irq_o, 0);

    // auto-reload with W1C between expiries
    bus_write(3'd0, 8'h00);
    bus_write(3'd1, 8'h00);
    bus_write(3'd2, 8'h04);
    bus_write(3'd0, 8'h07);
    n2 = last_commit;
    wait_irq(n1);
    check("auto_first", n1 - n2, 5);
    bus_write(3'd4, 8'h01);
    check("auto_irq_cleared", irq_o, 0);
    wait_irq(n2);
    check("auto_period", n2 - n1, 5);

    // W1C commit lands on the expiry edge
    while (cyc_n < n2 + 3) @(negedge clk);
    bus_write(3'd4, 8'h01);
    check("w1c_edge_aligned", last_commit - n2, 5);
    check("w1c_irq", irq_o, 1);
    read_expect("w1c_flag", 3'd4, 8'h01);
    bus_write(3'd0, 8'h00);
    bus_write(3'd4, 8'h01);

    // bus corner cases
    bus_write(3'd1, 8'h5A);
    bus_write(3'd2, 8'h33);
    bus_write(3'd6, 8'hFF);
    @(negedge clk);
    dir = 3'd1; dat = 8'h11; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    #2 stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk);
    #1 check("glitch_noack", ack_o, 0);
    @(negedge clk);
    dir = 3'd1; dat = 8'h22; we = 1'b1; stb = 1'b1; cyc = 1'b0;
    @(posedge clk);
    #1 check("nocyc_noack", ack_o, 0);
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    read_expect("corner_ctrl", 3'd0, 8'h00);
    read_expect("corner_presc", 3'd1, 8'h5A);
    read_expect("corner_reload", 3'd2, 8'h33);
    read_expect("corner_count", 3'd3, 8'h33);
    read_expect("corner_status", 3'd4, 8'h00);
    read_expect("corner_a6", 3'd6, 8'h00);

    // randomized traffic against the model
    for (int s = 0; s < 8; s++) begin
      bus_write(3'd0, 8'h00);
      bus_write(3'd4, 8'h01);
      bus_write(3'd1, 8'($urandom_range(0, 3)));
      bus_write(3'd2, 8'($urandom_range(0, 7)));
      bus_write(3'd0, 8'(1 | ($urandom_range(0, 3) << 1)));
      for (int k = 0; k < 40; k++) begin
        case ($urandom_range(0, 6))
          0: repeat ($urandom_range(1, 4)) @(negedge clk);
          1: bus_read(3'($urandom_range(0, 7)), d);
          2: bus_write(3'd4, 8'($urandom_range(0, 1)));
          3: bus_write(3'd2, 8'($urandom_range(0, 7)));
          4: bus_write(3'd0, 8'($urandom));
          5: begin
            @(negedge clk);
            dir = 3'd1; dat = 8'($urandom); we = 1'b1; stb = 1'b1; cyc = 1'b0;
            @(negedge clk);
            stb = 1'b0; we = 1'b0;
          end
          default: bus_write(3'($urandom_range(5, 7)), 8'($urandom));
        endcase
      end
    end

    // reset asserted while a write ack is high
    bus_write(3'd1, 8'h77);
    @(negedge clk);
    dir = 3'd0; dat = 8'h07; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    @(posedge clk);
    #1 check("rst_mid_ack_hi", ack_o, 1);
    rst = 1'b1;
    #1 check("rst_mid_ack_drop", ack_o, 0);
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    read_all_reset("rst_mid_read");
    check("rst_mid_irq", irq_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
